uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sampler.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Build option: UART_RX_MAJORITY_EN selects 3-sample majority voting in uart_rx_sampler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and line sampler for uart_rx_ctrl.
// Build option: UART_RX_MAJORITY_EN votes over edges mid-1, mid and mid+1;
// otherwise the single sample at edge mid (prescale/2) is used. Bit timing is
// the same either way: bit_done fires on edge prescale-1.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PSW = 6
) (
   input  logic           clk_rx,
   input  logic           rst,
   input  logic           clear,
   input  logic           enable,
   input  logic           rx_in,
   input  logic [PSW-1:0] prescale,
   output logic           bit_val,
   output logic           bit_done
);

   logic [PSW-1:0] edge_cnt;
   logic [PSW-1:0] mid_edge;
   logic [PSW-1:0] last_edge;

   assign mid_edge  = prescale >> 1;
   assign last_edge = prescale - PSW'(1);
   assign bit_done  = enable && (edge_cnt == last_edge);

   // Edge counter: held at zero while idle, wraps at the end of each bit.
   always_ff @(posedge clk_rx or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
      end else if (clear) begin
         edge_cnt <= '0;
      end else if (enable) begin
         edge_cnt <= bit_done ? '0 : edge_cnt + PSW'(1);
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] smp;

   // Capture three samples around the bit centre for voting.
   always_ff @(posedge clk_rx or negedge rst) begin
      if (!rst) begin
         smp <= '0;
      end else if (enable) begin
         if (edge_cnt == mid_edge - PSW'(1)) smp[0] <= rx_in;
         if (edge_cnt == mid_edge)           smp[1] <= rx_in;
         if (edge_cnt == mid_edge + PSW'(1)) smp[2] <= rx_in;
      end
   end

   assign bit_val = maj3(smp[0], smp[1], smp[2]);
`else
   logic smp;

   // Capture the single centre sample of the bit.
   always_ff @(posedge clk_rx or negedge rst) begin
      if (!rst) begin
         smp <= 1'b0;
      end else if (enable && (edge_cnt == mid_edge)) begin
         smp <= rx_in;
      end
   end

   assign bit_val = smp;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, data shift register, parity/stop checks.
// Build option: UART_RX_MAJORITY_EN (see uart_rx_sampler) changes only how a
// bit value is decided, never frame timing.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level; config inputs latched on exit
//   START  | timing the start bit; a high centre sample aborts as a glitch
//   DATA   | shifting DWIDTH data bits, LSB first
//   PARITY | checking the parity bit against the received data
//   STOP   | checking the stop bit; frame resolves after its last edge
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int PSW    = 6
) (
   input  logic              clk_rx,
   input  logic              rst,
   input  logic              rx_in,
   input  logic [PSW-1:0]    prescale,
   input  logic              par_en,
   input  logic              par_typ,
   output logic [DWIDTH-1:0] p_data_rx,
   output logic              data_valid_rx,
   output logic              par_err,
   output logic              stp_err,
   output logic              busy
);

   localparam int BCW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

   rx_state_e         state_q, state_d;
   logic [PSW-1:0]    psc_q, psc_d;
   logic              pen_q, pen_d;
   logic              ptyp_q, ptyp_d;
   logic [DWIDTH-1:0] shift_q, shift_d;
   logic [DWIDTH-1:0] pdata_d;
   logic [BCW-1:0]    bit_idx_q, bit_idx_d;
   logic              perr_q, perr_d;
   logic              dv_d, pe_d, se_d;
   logic              samp_clear, samp_en;
   logic              bit_val, bit_done;

   assign samp_clear = (state_q == IDLE);
   assign samp_en    = (state_q != IDLE);
   assign busy       = (state_q != IDLE);

   uart_rx_sampler #(.PSW(PSW)) u_sampler (
      .clk_rx   (clk_rx),
      .rst      (rst),
      .clear    (samp_clear),
      .enable   (samp_en),
      .rx_in    (rx_in),
      .prescale (psc_q),
      .bit_val  (bit_val),
      .bit_done (bit_done)
   );

   // Next-state, datapath and one-cycle result pulses.
   always_comb begin
      state_d   = state_q;
      psc_d     = psc_q;
      pen_d     = pen_q;
      ptyp_d    = ptyp_q;
      shift_d   = shift_q;
      pdata_d   = p_data_rx;
      bit_idx_d = bit_idx_q;
      perr_d    = perr_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_in) begin
               state_d   = START;
               psc_d     = prescale;
               pen_d     = par_en;
               ptyp_d    = par_typ;
               perr_d    = 1'b0;
               bit_idx_d = '0;
            end
         end
         START: begin
            if (bit_done) state_d = bit_val ? IDLE : DATA;
         end
         DATA: begin
            if (bit_done) begin
               shift_d             = shift_q >> 1;
               shift_d[DWIDTH-1]   = bit_val;
               if (bit_idx_q == BCW'(DWIDTH - 1)) begin
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BCW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               perr_d  = bit_val != ((^shift_q) ^ (ptyp_q == PAR_ODD));
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!bit_val) begin
                  se_d = 1'b1;
               end else if (perr_q) begin
                  pe_d = 1'b1;
               end else begin
                  dv_d    = 1'b1;
                  pdata_d = shift_q;
               end
               // A low line right now is the next start bit.
               if (!rx_in) begin
                  state_d   = START;
                  psc_d     = prescale;
                  pen_d     = par_en;
                  ptyp_d    = par_typ;
                  perr_d    = 1'b0;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_rx or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Frame datapath and output registers.
   always_ff @(posedge clk_rx or negedge rst) begin
      if (!rst) begin
         psc_q         <= '0;
         pen_q         <= 1'b0;
         ptyp_q        <= 1'b0;
         shift_q       <= '0;
         bit_idx_q     <= '0;
         perr_q        <= 1'b0;
         p_data_rx     <= '0;
         data_valid_rx <= 1'b0;
         par_err       <= 1'b0;
         stp_err       <= 1'b0;
      end else begin
         psc_q         <= psc_d;
         pen_q         <= pen_d;
         ptyp_q        <= ptyp_d;
         shift_q       <= shift_d;
         bit_idx_q     <= bit_idx_d;
         perr_q        <= perr_d;
         p_data_rx     <= pdata_d;
         data_valid_rx <= dv_d;
         par_err       <= pe_d;
         stp_err       <= se_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized
// frames, compared against a frame-level model of expected result events.
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          clk_rx  = 1'b0;
   logic          rst     = 1'b0;
   logic          rx_in   = 1'b1;
   logic [PW-1:0] prescale = PW'(8);
   logic          par_en  = 1'b0;
   logic          par_typ = 1'b0;
   logic [DW-1:0] p_data_rx;
   logic          data_valid_rx, par_err, stp_err, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int            t;
      int            kind;   // 0 data_valid, 1 par_err, 2 stp_err
      logic [DW-1:0] pdata;
   } evt_t;

   evt_t          exp_q[$];
   int            dv_times[$];
   logic [DW-1:0] model_pdata = '0;

   uart_rx_ctrl #(.DWIDTH(DW), .PSW(PW)) dut (
      .clk_rx        (clk_rx),
      .rst           (rst),
      .rx_in         (rx_in),
      .prescale      (prescale),
      .par_en        (par_en),
      .par_typ       (par_typ),
      .p_data_rx     (p_data_rx),
      .data_valid_rx (data_valid_rx),
      .par_err       (par_err),
      .stp_err       (stp_err),
      .busy          (busy)
   );

   always #5 clk_rx = ~clk_rx;

   always @(posedge clk_rx) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every result pulse must match the oldest outstanding model event.
   always @(negedge clk_rx) begin : monitor
      evt_t e;
      int   kind;
      if (rst && (data_valid_rx || par_err || stp_err)) begin
         kind = stp_err ? 2 : (par_err ? 1 : 0);
         check("pulse_onehot", $countones({data_valid_rx, par_err, stp_err}), 1);
         check("evt_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("evt_time", cyc, e.t);
            check("evt_kind", kind, e.kind);
            check("evt_pdata", p_data_rx, e.pdata);
         end
         if (data_valid_rx) dv_times.push_back(cyc);
      end
   end

   // Drive one frame starting right after a negedge; par_force<0 means correct parity.
   task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen,
                             input bit ptyp, input int par_force, input bit bad_stop);
      evt_t e;
      logic par_bit;
      int   kind;
      par_bit = (par_force < 0) ? ((^d) ^ ptyp) : par_force[0];
      if (bad_stop)
         kind = 2;
      else if (pen && ((($countones(d) + int'(par_bit)) % 2) != int'(ptyp)))
         kind = 1;
      else
         kind = 0;
      if (kind == 0) model_pdata = d;
      e.t     = cyc + 1 + (2 + DW + int'(pen)) * p;
      e.kind  = kind;
      e.pdata = model_pdata;
      exp_q.push_back(e);

      prescale = PW'(p);
      par_en   = pen;
      par_typ  = ptyp;
      rx_in    = 1'b0;
      @(negedge clk_rx);
      // Config changes mid-frame must be ignored.
      prescale = PW'(8 << $urandom_range(2, 0));
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      repeat (p - 1) @(negedge clk_rx);
      for (int i = 0; i < DW; i++) begin
         rx_in = d[i];
         repeat (p) @(negedge clk_rx);
      end
      if (pen) begin
         rx_in = par_bit;
         repeat (p) @(negedge clk_rx);
      end
      rx_in = !bad_stop;
      repeat (p) @(negedge clk_rx);
      rx_in = 1'b1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int gap;
      int p;
      repeat (3) @(negedge clk_rx);
      check("rst_pdata", p_data_rx, 0);
      check("rst_dv", data_valid_rx, 0);
      check("rst_perr", par_err, 0);
      check("rst_serr", stp_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk_rx);
      check("idle_busy", busy, 0);

      // prescale 8, no parity, 0xA5: valid 80 cycles after start
      send_frame(8'hA5, 8, 1'b0, 1'b0, -1, 1'b0);
      repeat (4) @(negedge clk_rx);
      check("a5_pdata", p_data_rx, 8'hA5);
      check("a5_drained", exp_q.size(), 0);

      // prescale 16, even parity, 0x3C with parity bit 1 -> par_err
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1, 1'b0);
      repeat (4) @(negedge clk_rx);
      check("par_pdata_held", p_data_rx, 8'hA5);
      check("par_drained", exp_q.size(), 0);

      // prescale 8, 0x81 with stop bit 0 -> stp_err
      send_frame(8'h81, 8, 1'b0, 1'b0, -1, 1'b1);
      repeat (4) @(negedge clk_rx);
      check("stp_pdata_held", p_data_rx, 8'hA5);
      check("stp_drained", exp_q.size(), 0);

      // 2-cycle glitch at prescale 16
      prescale = PW'(16);
      rx_in = 1'b0;
      repeat (2) @(negedge clk_rx);
      rx_in = 1'b1;
      check("glitch_busy_hi", busy, 1);
      repeat (30) @(negedge clk_rx);
      check("glitch_busy_lo", busy, 0);
      check("glitch_pdata", p_data_rx, 8'hA5);

      // reset during data bit 4, then a clean 0x5A
      fork
         send_frame(8'h3C, 8, 1'b0, 1'b0, -1, 1'b0);
         begin
            repeat (5 * 8 + 4) @(negedge clk_rx);
            rst = 1'b0;
            #1;
            check("mid_rst_pdata", p_data_rx, 0);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_pulses", {data_valid_rx, par_err, stp_err}, 0);
            exp_q.delete();
            model_pdata = '0;
         end
      join
      @(negedge clk_rx);
      rst = 1'b1;
      repeat (3) @(negedge clk_rx);
      send_frame(8'h5A, 8, 1'b0, 1'b0, -1, 1'b0);
      repeat (4) @(negedge clk_rx);
      check("after_rst_pdata", p_data_rx, 8'h5A);

      // back-to-back at prescale 32
      dv_times.delete();
      send_frame(8'h55, 32, 1'b0, 1'b0, -1, 1'b0);
      send_frame(8'hAA, 32, 1'b0, 1'b0, -1, 1'b0);
      repeat (4) @(negedge clk_rx);
      check("b2b_count", dv_times.size(), 2);
      check("b2b_gap", (dv_times.size() >= 2) ? dv_times[1] - dv_times[0] : -1, 320);
      check("b2b_pdata", p_data_rx, 8'hAA);

      // randomized frames, including back-to-back and error frames
      for (int n = 0; n < 16; n++) begin
         gap = $urandom_range(3, 0);
         repeat (gap) @(negedge clk_rx);
         p = 8 << $urandom_range(2, 0);
         send_frame(DW'($urandom), p, 1'($urandom), 1'($urandom),
                    ($urandom_range(2, 0) == 0) ? int'($urandom_range(1, 0)) : -1,
                    $urandom_range(4, 0) == 0);
      end
      repeat (20) @(negedge clk_rx);
      check("final_drained", exp_q.size(), 0);
      check("final_pdata", p_data_rx, model_pdata);
      check("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
